// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment display driver.
package seven_seg_pkg;

    // Glyph codes: 0..15 are the hex digits themselves, followed by specials.
    typedef enum logic [4:0] {
        GLYPH_0     = 5'd0,
        GLYPH_1     = 5'd1,
        GLYPH_2     = 5'd2,
        GLYPH_3     = 5'd3,
        GLYPH_4     = 5'd4,
        GLYPH_5     = 5'd5,
        GLYPH_6     = 5'd6,
        GLYPH_7     = 5'd7,
        GLYPH_8     = 5'd8,
        GLYPH_9     = 5'd9,
        GLYPH_A     = 5'd10,
        GLYPH_B     = 5'd11,
        GLYPH_C     = 5'd12,
        GLYPH_D     = 5'd13,
        GLYPH_E     = 5'd14,
        GLYPH_F     = 5'd15,
        GLYPH_DASH  = 5'd16,
        GLYPH_H     = 5'd17,
        GLYPH_BLANK = 5'd18
    } glyph_t;

    localparam logic MODE_DEC = 1'b0;
    localparam logic MODE_HEX = 1'b1;

    typedef logic [1:0] digit_idx_t;

    // All segments off (active-low).
    localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/seven_seg_display_driver_seg7_glyph_decoder.sv
// Combinational map from glyph code to active-low {g,f,e,d,c,b,a} pattern.
module seg7_glyph_decoder
    import seven_seg_pkg::*;
(
    input  glyph_t     glyph,
    output logic [6:0] seg
);

    // Glyph lookup; anything unrecognised shows blank.
    always_comb begin
        seg = SEG_OFF;
        case (glyph)
            GLYPH_0:     seg = 7'b1000000;
            GLYPH_1:     seg = 7'b1111001;
            GLYPH_2:     seg = 7'b0100100;
            GLYPH_3:     seg = 7'b0110000;
            GLYPH_4:     seg = 7'b0011001;
            GLYPH_5:     seg = 7'b0010010;
            GLYPH_6:     seg = 7'b0000010;
            GLYPH_7:     seg = 7'b1111000;
            GLYPH_8:     seg = 7'b0000000;
            GLYPH_9:     seg = 7'b0010000;
            GLYPH_A:     seg = 7'b0001000;
            GLYPH_B:     seg = 7'b0000011;
            GLYPH_C:     seg = 7'b1000110;
            GLYPH_D:     seg = 7'b0100001;
            GLYPH_E:     seg = 7'b0000110;
            GLYPH_F:     seg = 7'b0001110;
            GLYPH_DASH:  seg = 7'b0111111;
            GLYPH_H:     seg = 7'b0001001;
            GLYPH_BLANK: seg = SEG_OFF;
            default:     seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_display_driver.sv
// Four-digit multiplexed common-anode display driver. Shows a signed 6-bit
// value as sign-magnitude decimal or as raw hex; inputs are captured once per
// scan frame so a frame never mixes two values.
module seven_seg_display_driver
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       display_mode,
    input  logic [5:0] display_result,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    digit_idx_t       digit_idx;
    logic [5:0]       snap_value;
    logic             snap_mode;

    logic [5:0]       mag;
    logic [1:0]       tens;
    logic [3:0]       ones;
    glyph_t           cur_glyph;
    logic [6:0]       cur_seg;

    assign tick = (tick_cnt == TICK_LAST);
    assign dp   = 1'b1;

    // Slot timer and digit index; the index steps once per completed slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            digit_idx <= '0;
        end else if (tick) begin
            tick_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            tick_cnt  <= tick_cnt + CNT_W'(1);
        end
    end

    // Capture the inputs at the end of digit 3 so the next frame is coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_value <= '0;
            snap_mode  <= MODE_DEC;
        end else if (tick && (digit_idx == 2'd3)) begin
            snap_value <= display_result;
            snap_mode  <= display_mode;
        end
    end

    // Magnitude and tens/ones split; magnitude never exceeds 32.
    always_comb begin
        mag  = snap_value[5] ? 6'(-snap_value) : snap_value;
        tens = 2'd0;
        ones = mag[3:0];
        if (mag >= 6'd30) begin
            tens = 2'd3;
            ones = 4'(mag - 6'd30);
        end else if (mag >= 6'd20) begin
            tens = 2'd2;
            ones = 4'(mag - 6'd20);
        end else if (mag >= 6'd10) begin
            tens = 2'd1;
            ones = 4'(mag - 6'd10);
        end
    end

    // Choose the glyph for the digit currently being scanned.
    always_comb begin
        cur_glyph = GLYPH_BLANK;
        if (snap_mode == MODE_HEX) begin
            case (digit_idx)
                2'd0:    cur_glyph = glyph_t'({1'b0, snap_value[3:0]});
                2'd1:    cur_glyph = glyph_t'({3'b000, snap_value[5:4]});
                2'd2:    cur_glyph = GLYPH_BLANK;
                default: cur_glyph = GLYPH_H;
            endcase
        end else begin
            case (digit_idx)
                2'd0:    cur_glyph = glyph_t'({1'b0, ones});
                2'd1:    cur_glyph = (tens == 2'd0) ? GLYPH_BLANK
                                                    : glyph_t'({3'b000, tens});
                2'd2:    cur_glyph = snap_value[5] ? GLYPH_DASH : GLYPH_BLANK;
                default: cur_glyph = GLYPH_BLANK;
            endcase
        end
    end

    seg7_glyph_decoder u_glyph_decoder (
        .glyph (cur_glyph),
        .seg   (cur_seg)
    );

    // Registered anode/cathode drive, one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
        end else begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= cur_seg;
        end
    end

endmodule
